// File: rtl/issue_starvation_guard_pkg.sv
// Shared scheduler types for the issue-select stage starvation guard.
// Queue geometry, starvation thresholds and guard FSM encoding.
package issue_starvation_guard_pkg;

  localparam int ISSUE_QUEUE_ENTRY_NUM = 16;
  localparam int ISSUE_QUEUE_INDEX_WIDTH =
    $clog2(ISSUE_QUEUE_ENTRY_NUM);

  localparam int ISSUE_STARVE_THRESHOLD = 32;
  localparam int ISSUE_STARVE_CNT_WIDTH = 6;
  localparam int ISSUE_STARVE_ABANDON = 4;
  localparam int ISSUE_STARVE_COOLDOWN = 8;

  typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]
    IssueQueueOneHotPath;
  typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0]
    IssueQueueIndexPath;

  typedef enum logic [1:0] {
    SG_NORMAL,
    SG_FORCE,
    SG_COOLDOWN
  } StarvationGuardState;

endpackage

// File: rtl/issue_starvation_guard_age.sv
// Per-entry saturating wait counters and the starved vector.
// Ports: clk, rst_n, flush, req, grant in; starved out.
module starvation_age_counter_array
  import issue_starvation_guard_pkg::*;
#(
  parameter int ENTRY_NUM = ISSUE_QUEUE_ENTRY_NUM,
  parameter int AGE_THRESHOLD = ISSUE_STARVE_THRESHOLD,
  parameter int CNT_WIDTH = ISSUE_STARVE_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [ENTRY_NUM-1:0] req,
  input  logic [ENTRY_NUM-1:0] grant,
  output logic [ENTRY_NUM-1:0] starved
);

  localparam logic [CNT_WIDTH-1:0] THR =
    CNT_WIDTH'(AGE_THRESHOLD);

  logic [CNT_WIDTH-1:0] wc [ENTRY_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++)
        wc[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (flush || !req[i] || grant[i])
          wc[i] <= '0;
        else if (wc[i] != THR)
          wc[i] <= wc[i] + 1'b1;
      end
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      starved[i] = (wc[i] == THR);
  end

endmodule

// File: rtl/issue_starvation_guard.sv
// Starvation guard in front of one issue picker: forces a starved entry.
// Ports: req/grant in, maskedReq/forceActive/victimPtr/starveEvents out.
module issue_starvation_guard
  import issue_starvation_guard_pkg::*;
#(
  parameter int ENTRY_NUM = ISSUE_QUEUE_ENTRY_NUM,
  parameter int AGE_THRESHOLD = ISSUE_STARVE_THRESHOLD,
  parameter int CNT_WIDTH = ISSUE_STARVE_CNT_WIDTH,
  parameter int ABANDON_CYCLES = ISSUE_STARVE_ABANDON,
  parameter int COOLDOWN_CYCLES = ISSUE_STARVE_COOLDOWN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [ENTRY_NUM-1:0]         req,
  input  logic [ENTRY_NUM-1:0]         grant,
  output logic [ENTRY_NUM-1:0]         maskedReq,
  output logic                         forceActive,
  output logic [$clog2(ENTRY_NUM)-1:0] victimPtr,
  output logic [15:0]                  starveEvents
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int IDLE_W = $clog2(ABANDON_CYCLES + 1);
  localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'(ABANDON_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD =
    COOL_W'(COOLDOWN_CYCLES - 1);
  localparam logic [ENTRY_NUM-1:0] ONE =
    {{(ENTRY_NUM-1){1'b0}}, 1'b1};

  StarvationGuardState state, stateNext;

  logic [IDX_W-1:0]     victim, victimNext, lowIdx;
  logic [IDLE_W-1:0]    idleCnt, idleNext;
  logic [COOL_W-1:0]    coolCnt, coolNext;
  logic [15:0]          eventsNext;
  logic [ENTRY_NUM-1:0] starved, victimOneHot;
  logic                 anyStarved, victimReq, victimGrant;

  starvation_age_counter_array #(
    .ENTRY_NUM     (ENTRY_NUM),
    .AGE_THRESHOLD (AGE_THRESHOLD),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .req     (req),
    .grant   (grant),
    .starved (starved)
  );

  assign victimOneHot = ONE << victim;
  assign victimReq = |(req & victimOneHot);
  assign victimGrant = |(grant & victimOneHot);
  assign anyStarved = |starved;

  // Scan high to low so the lowest starved index wins.
  always_comb begin
    lowIdx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (starved[i]) lowIdx = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SG_NORMAL;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = SG_NORMAL;
    end else begin
      unique case (state)
        SG_NORMAL:
          if (anyStarved) stateNext = SG_FORCE;
        SG_FORCE:
          if (victimGrant ||
              (!victimReq && idleCnt == IDLE_LAST))
            stateNext = SG_COOLDOWN;
        SG_COOLDOWN:
          if (coolCnt == '0) stateNext = SG_NORMAL;
        default:
          stateNext = SG_NORMAL;
      endcase
    end
  end

  always_comb begin
    maskedReq = req;
    forceActive = 1'b0;
    victimPtr = '0;
    if (state == SG_FORCE) begin
      maskedReq = req & victimOneHot;
      forceActive = 1'b1;
      victimPtr = victim;
    end
  end

  always_comb begin
    victimNext = victim;
    idleNext = idleCnt;
    coolNext = coolCnt;
    eventsNext = starveEvents;
    if (flush) begin
      victimNext = '0;
      idleNext = '0;
      coolNext = '0;
    end else begin
      unique case (state)
        SG_NORMAL: begin
          if (anyStarved) begin
            victimNext = lowIdx;
            idleNext = '0;
            if (starveEvents != 16'hFFFF)
              eventsNext = starveEvents + 16'd1;
          end
        end
        SG_FORCE: begin
          idleNext = victimReq ? '0 : idleCnt + 1'b1;
          if (stateNext == SG_COOLDOWN) begin
            coolNext = COOL_LOAD;
            idleNext = '0;
            victimNext = '0;
          end
        end
        SG_COOLDOWN: begin
          if (coolCnt != '0)
            coolNext = coolCnt - 1'b1;
        end
        default: begin
          victimNext = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim <= '0;
      idleCnt <= '0;
      coolCnt <= '0;
      starveEvents <= '0;
    end else begin
      victim <= victimNext;
      idleCnt <= idleNext;
      coolCnt <= coolNext;
      starveEvents <= eventsNext;
    end
  end

  // A picker that grants anything but the victim while forced is broken.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == SG_FORCE) |-> ((grant & ~victimOneHot) == '0));

endmodule

// File: tb/tb_issue_starvation_guard.sv
// Directed table-driven bench for issue_starvation_guard.
// Rows hold inputs for N cycles; outputs compared every cycle.
module tb_issue_starvation_guard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] req;
  logic [15:0] grant;
  logic [15:0] maskedReq;
  logic        forceActive;
  logic [3:0]  victimPtr;
  logic [15:0] starveEvents;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic [15:0] req;
    logic [15:0] grant;
    logic        flush;
    logic [15:0] mReq;
    logic        fAct;
    logic [3:0]  vPtr;
    logic [15:0] ev;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  issue_starvation_guard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req          (req),
    .grant        (grant),
    .maskedReq    (maskedReq),
    .forceActive  (forceActive),
    .victimPtr    (victimPtr),
    .starveEvents (starveEvents)
  );

  function automatic vec_t mk(
    int n, logic [15:0] r, logic [15:0] g, logic f,
    logic [15:0] m, logic fa, logic [3:0] vp, logic [15:0] e);
    vec_t x;
    x.n = n; x.req = r; x.grant = g; x.flush = f;
    x.mReq = m; x.fAct = fa; x.vPtr = vp; x.ev = e;
    return x;
  endfunction

  task automatic chk(string nm, logic [15:0] got,
                     logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chkAll(string tag, logic [15:0] m,
                        logic fa, logic [3:0] vp,
                        logic [15:0] e);
    chk({tag, " maskedReq"}, maskedReq, m);
    chk({tag, " forceActive"}, 16'(forceActive), 16'(fa));
    chk({tag, " victimPtr"}, 16'(victimPtr), 16'(vp));
    chk({tag, " starveEvents"}, starveEvents, e);
  endtask

  initial begin
    // entry 5 starves, forced, granted, cooldown
    vecs.push_back(mk(33, 16'h0020, 0, 0, 16'h0020, 0, 0, 0));
    vecs.push_back(mk(2, 16'hFFFF, 0, 0, 16'h0020, 1, 5, 1));
    vecs.push_back(mk(1, 16'hFFFF, 16'h0020, 0,
                      16'h0020, 1, 5, 1));
    vecs.push_back(mk(8, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 1));
    vecs.push_back(mk(2, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
    // entries 3 and 9 starve together
    vecs.push_back(mk(33, 16'h0208, 0, 0, 16'h0208, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0208, 0, 0, 16'h0008, 1, 3, 2));
    vecs.push_back(mk(1, 16'h0208, 16'h0008, 0,
                      16'h0008, 1, 3, 2));
    vecs.push_back(mk(8, 16'h0208, 0, 0, 16'h0208, 0, 0, 2));
    vecs.push_back(mk(1, 16'h0208, 0, 0, 16'h0208, 0, 0, 2));
    vecs.push_back(mk(1, 16'h0208, 16'h0200, 0,
                      16'h0200, 1, 9, 3));
    vecs.push_back(mk(8, 16'h0000, 0, 0, 16'h0000, 0, 0, 3));
    // entry 0: idle 3 then reassert holds, idle 4 abandons
    vecs.push_back(mk(33, 16'h0001, 0, 0, 16'h0001, 0, 0, 3));
    vecs.push_back(mk(1, 16'h0001, 0, 0, 16'h0001, 1, 0, 4));
    vecs.push_back(mk(3, 16'h0000, 0, 0, 16'h0000, 1, 0, 4));
    vecs.push_back(mk(1, 16'h0001, 0, 0, 16'h0001, 1, 0, 4));
    vecs.push_back(mk(4, 16'h0002, 0, 0, 16'h0000, 1, 0, 4));
    vecs.push_back(mk(8, 16'h0002, 0, 0, 16'h0002, 0, 0, 4));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0000, 0, 0, 4));
    // entry 15: flush (with grant) mid-force clears the ages
    vecs.push_back(mk(33, 16'h8000, 0, 0, 16'h8000, 0, 0, 4));
    vecs.push_back(mk(1, 16'h8000, 0, 0, 16'h8000, 1, 15, 5));
    vecs.push_back(mk(1, 16'hFFFF, 16'h8000, 1,
                      16'h8000, 1, 15, 5));
    vecs.push_back(mk(1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 5));
    vecs.push_back(mk(32, 16'h8000, 0, 0, 16'h8000, 0, 0, 5));
    vecs.push_back(mk(1, 16'h8001, 0, 0, 16'h8000, 1, 15, 6));

    rst_n = 1'b0;
    flush = 1'b0;
    grant = 16'h0000;
    req = 16'h1234;
    #2;
    chkAll("reset", 16'h1234, 1'b0, 4'd0, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    req = 16'h0000;

    for (int r = 0; r < vecs.size(); r++) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        @(negedge clk);
        req = vecs[r].req;
        grant = vecs[r].grant;
        flush = vecs[r].flush;
        #1;
        chkAll($sformatf("row%0d.%0d", r, c), vecs[r].mReq,
               vecs[r].fAct, vecs[r].vPtr, vecs[r].ev);
      end
    end

    // async reset while forcing entry 15
    @(negedge clk);
    req = 16'hFFFF;
    grant = 16'h0000;
    flush = 1'b0;
    #1;
    chkAll("preRst", 16'h8000, 1'b1, 4'd15, 16'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chkAll("asyncRst", 16'hFFFF, 1'b0, 4'd0, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    req = 16'h0004;
    #1;
    chkAll("postRst", 16'h0004, 1'b0, 4'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
